// File: rtl/elev_pkg.sv
// Shared types and helpers for the 3-floor elevator scheduler.
// Holds the state encoding, direction and floor codes, and the SCAN direction choice.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OPEN = 2'b01,
        MOVE = 2'b10
    } state_e;

    typedef logic [1:0] dir_t;
    typedef logic [1:0] floor_t;

    localparam dir_t DIR_NONE = 2'b00;
    localparam dir_t DIR_UP   = 2'b01;
    localparam dir_t DIR_DOWN = 2'b10;

    localparam floor_t FLOOR_1 = 2'b01;
    localparam floor_t FLOOR_2 = 2'b10;
    localparam floor_t FLOOR_3 = 2'b11;

    function automatic logic [2:0] floor_mask(input floor_t f);
        logic [2:0] m;
        case (f)
            FLOOR_1: m = 3'b001;
            FLOOR_2: m = 3'b010;
            FLOOR_3: m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Keep heading while calls lie ahead, otherwise reverse; with no heading the
    // nearest call wins and the floor-2 tie resolves upward.
    function automatic dir_t scan_dir(input floor_t cur, input logic [2:0] calls, input dir_t heading);
        logic above;
        logic below;
        dir_t nd;
        above = (cur == FLOOR_1) ? (calls[1] | calls[2]) : ((cur == FLOOR_2) ? calls[2] : 1'b0);
        below = (cur == FLOOR_3) ? (calls[0] | calls[1]) : ((cur == FLOOR_2) ? calls[0] : 1'b0);
        if (heading == DIR_DOWN) begin
            nd = below ? DIR_DOWN : (above ? DIR_UP : DIR_NONE);
        end else begin
            nd = above ? DIR_UP : (below ? DIR_DOWN : DIR_NONE);
        end
        return nd;
    endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Call-switch, tick and alarm inputs plus car status outputs of the elevator scheduler.
// The master side drives stimulus; the scheduler is the slave.
interface elevator_scheduler_if;
    logic       step;
    logic       CH1;
    logic       CH2;
    logic       CH3;
    logic       alarm;
    logic [1:0] floor;
    logic [1:0] dir;
    logic       door_open;
    logic [2:0] pending;
    logic       busy;

    modport master (
        output step, CH1, CH2, CH3, alarm,
        input  floor, dir, door_open, pending, busy
    );

    modport slave (
        input  step, CH1, CH2, CH3, alarm,
        output floor, dir, door_open, pending, busy
    );
endinterface

// File: rtl/call_latch.sv
// Synchronises the three call switches, detects rising edges and keeps the pending
// call register; a clear always beats a set on the same bit.
module call_latch (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ch,
    input  logic [2:0] set_block,
    input  logic [2:0] clr,
    output logic [2:0] call_edge,
    output logic [2:0] pending
);
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] prev_q;
    logic [2:0] pending_q;
    logic [2:0] pending_d;

    assign call_edge = sync2_q & ~prev_q;
    assign pending   = pending_q;

    always_comb begin
        pending_d = (pending_q | (call_edge & ~set_block)) & ~clr;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= ch;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
        end
    end
endmodule

// File: rtl/elevator_scheduler.sv
// SCAN scheduler for a 3-floor car: step-paced FSM with door and travel timers.
// Call capture lives in call_latch; all outputs come straight from flops.
module elevator_scheduler
    import elev_pkg::*;
#(
    parameter int     DOOR_TICKS  = 3,
    parameter int     MOVE_TICKS  = 2,
    parameter floor_t RESET_FLOOR = FLOOR_1
) (
    input logic                 clk,
    input logic                 reset,
    elevator_scheduler_if.slave bus
);
    localparam int MAX_TICKS = (DOOR_TICKS > MOVE_TICKS) ? DOOR_TICKS : MOVE_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    typedef logic [TW-1:0] tick_t;
    localparam tick_t DOOR_LOAD = tick_t'(DOOR_TICKS);
    localparam tick_t MOVE_LOAD = tick_t'(MOVE_TICKS);
    localparam tick_t ONE       = tick_t'(1);

    state_e     state_q, state_d;
    floor_t     floor_q, floor_d;
    dir_t       dir_q, dir_d;
    tick_t      door_q, door_d;
    tick_t      move_q, move_d;
    logic       door_open_q, door_open_d;
    logic       busy_q, busy_d;
    logic [2:0] pend;
    logic [2:0] cedge;
    logic [2:0] clr;
    logic [2:0] cur_mask;
    logic [2:0] arr_mask;
    dir_t       nd;

    call_latch u_calls (
        .clk       (clk),
        .reset     (reset),
        .ch        ({bus.CH3, bus.CH2, bus.CH1}),
        .set_block ((state_q == OPEN) ? cur_mask : 3'b000),
        .clr       (clr),
        .call_edge (cedge),
        .pending   (pend)
    );

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        door_d   = door_q;
        move_d   = move_q;
        clr      = 3'b000;
        cur_mask = floor_mask(floor_q);
        arr_mask = 3'b000;
        nd       = DIR_NONE;
        case (state_q)
            IDLE: if (bus.step) begin
                if ((pend & cur_mask) != 3'b000) begin
                    state_d = OPEN;
                    clr     = cur_mask;
                    door_d  = DOOR_LOAD;
                end else begin
                    nd      = scan_dir(floor_q, pend, DIR_NONE);
                    dir_d   = nd;
                    if (nd != DIR_NONE) begin
                        state_d = MOVE;
                        move_d  = MOVE_LOAD;
                    end
                end
            end
            OPEN: begin
                // A fresh call for this floor keeps the door open instead of queuing.
                if ((cedge & cur_mask) != 3'b000) begin
                    door_d = DOOR_LOAD;
                end else if (bus.step) begin
                    if (bus.alarm) begin
                        door_d = DOOR_LOAD;
                    end else if (door_q <= ONE) begin
                        door_d = '0;
                        nd     = scan_dir(floor_q, pend, dir_q);
                        dir_d  = nd;
                        if (nd != DIR_NONE) begin
                            state_d = MOVE;
                            move_d  = MOVE_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        door_d = door_q - ONE;
                    end
                end
            end
            MOVE: if (bus.step) begin
                if (move_q <= ONE) begin
                    if (dir_q == DIR_UP && floor_q != FLOOR_3) begin
                        floor_d = floor_q + 2'd1;
                    end else if (dir_q == DIR_DOWN && floor_q != FLOOR_1) begin
                        floor_d = floor_q - 2'd1;
                    end
                    arr_mask = floor_mask(floor_d);
                    if ((pend & arr_mask) != 3'b000) begin
                        state_d = OPEN;
                        clr     = arr_mask;
                        door_d  = DOOR_LOAD;
                        move_d  = '0;
                    end else begin
                        move_d  = MOVE_LOAD;
                    end
                end else begin
                    move_d = move_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        door_open_d = (state_d == OPEN);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            floor_q     <= RESET_FLOOR;
            dir_q       <= DIR_NONE;
            door_q      <= '0;
            move_q      <= '0;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_q       <= dir_d;
            door_q      <= door_d;
            move_q      <= move_d;
            door_open_q <= door_open_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.floor     = floor_q;
    assign bus.dir       = dir_q;
    assign bus.door_open = door_open_q;
    assign bus.pending   = pend;
    assign bus.busy      = busy_q;

    a_floor_sat: assert property (@(posedge clk) disable iff (!reset)
        (state_q == MOVE) |-> !((dir_q == DIR_UP && floor_q == FLOOR_3) ||
                                (dir_q == DIR_DOWN && floor_q == FLOOR_1)));
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: expected outputs are queued as stimulus is
// applied and popped against the car status once the step that causes them has landed.
module tb_elevator_scheduler;
    import elev_pkg::*;

    typedef enum int {F_FLOOR, F_DIR, F_DOOR, F_PEND, F_BUSY} field_e;
    typedef struct {
        string      tag;
        field_e     field;
        logic [3:0] val;
    } exp_t;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    exp_t sb[$];

    elevator_scheduler_if bus ();

    elevator_scheduler #(
        .DOOR_TICKS  (3),
        .MOVE_TICKS  (2),
        .RESET_FLOOR (2'b01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sample(input field_e f);
        logic [3:0] v;
        case (f)
            F_FLOOR: v = {2'b00, bus.floor};
            F_DIR:   v = {2'b00, bus.dir};
            F_DOOR:  v = {3'b000, bus.door_open};
            F_PEND:  v = {1'b0, bus.pending};
            default: v = {3'b000, bus.busy};
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input field_e f, input logic [3:0] v);
        exp_t e;
        e.tag   = tag;
        e.field = f;
        e.val   = v;
        sb.push_back(e);
    endtask

    task automatic push_all(input string tag, input logic [1:0] f, input logic [1:0] d,
                            input logic door, input logic [2:0] p, input logic b);
        push({tag, ".floor"}, F_FLOOR, {2'b00, f});
        push({tag, ".dir"},   F_DIR,   {2'b00, d});
        push({tag, ".door"},  F_DOOR,  {3'b000, door});
        push({tag, ".pend"},  F_PEND,  {1'b0, p});
        push({tag, ".busy"},  F_BUSY,  {3'b000, b});
    endtask

    task automatic check();
        exp_t       e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = sample(e.field);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) do_step();
    endtask

    task automatic step_expect(input string tag, input logic [1:0] f, input logic [1:0] d,
                               input logic door, input logic [2:0] p, input logic b);
        push_all(tag, f, d, door, p, b);
        do_step();
        check();
    endtask

    task automatic pulse(input logic [2:0] m);
        {bus.CH3, bus.CH2, bus.CH1} = m;
        repeat (3) tick();
        {bus.CH3, bus.CH2, bus.CH1} = 3'b000;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        bus.step  = 1'b0;
        bus.alarm = 1'b0;
        {bus.CH3, bus.CH2, bus.CH1} = 3'b000;

        // Reset state, held and just released
        repeat (2) tick();
        push_all("rst_hold", 2'b01, 2'b00, 1'b0, 3'b000, 1'b0);
        check();
        reset = 1'b1;
        tick();
        push_all("rst_rel", 2'b01, 2'b00, 1'b0, 3'b000, 1'b0);
        check();

        // Floor 1 to floor 3
        pulse(3'b100);
        push("t2_pend", F_PEND, 4'b0100);
        check();
        step_expect("t2_go",   2'b01, 2'b01, 1'b0, 3'b100, 1'b1);
        step_expect("t2_m1",   2'b01, 2'b01, 1'b0, 3'b100, 1'b1);
        step_expect("t2_f2",   2'b10, 2'b01, 1'b0, 3'b100, 1'b1);
        step_expect("t2_m3",   2'b10, 2'b01, 1'b0, 3'b100, 1'b1);
        step_expect("t2_arr",  2'b11, 2'b01, 1'b1, 3'b000, 1'b1);
        step_expect("t2_o1",   2'b11, 2'b01, 1'b1, 3'b000, 1'b1);
        step_expect("t2_o2",   2'b11, 2'b01, 1'b1, 3'b000, 1'b1);
        step_expect("t2_idle", 2'b11, 2'b00, 1'b0, 3'b000, 1'b0);

        pulse(3'b001);
        run_steps(8);
        push_all("t3_home", 2'b01, 2'b00, 1'b0, 3'b000, 1'b0);
        check();

        // Calls behind and ahead while climbing: serve 3, reverse, serve 1
        pulse(3'b100);
        step_expect("t3_go", 2'b01, 2'b01, 1'b0, 3'b100, 1'b1);
        pulse(3'b101);
        push("t3_both", F_PEND, 4'b0101);
        check();
        step_expect("t3_m1",   2'b01, 2'b01, 1'b0, 3'b101, 1'b1);
        step_expect("t3_f2",   2'b10, 2'b01, 1'b0, 3'b101, 1'b1);
        step_expect("t3_m3",   2'b10, 2'b01, 1'b0, 3'b101, 1'b1);
        step_expect("t3_arr3", 2'b11, 2'b01, 1'b1, 3'b001, 1'b1);
        step_expect("t3_o1",   2'b11, 2'b01, 1'b1, 3'b001, 1'b1);
        step_expect("t3_o2",   2'b11, 2'b01, 1'b1, 3'b001, 1'b1);
        step_expect("t3_rev",  2'b11, 2'b10, 1'b0, 3'b001, 1'b1);
        step_expect("t3_d1",   2'b11, 2'b10, 1'b0, 3'b001, 1'b1);
        step_expect("t3_df2",  2'b10, 2'b10, 1'b0, 3'b001, 1'b1);
        step_expect("t3_d3",   2'b10, 2'b10, 1'b0, 3'b001, 1'b1);
        step_expect("t3_arr1", 2'b01, 2'b10, 1'b1, 3'b000, 1'b1);
        run_steps(2);
        step_expect("t3_idle", 2'b01, 2'b00, 1'b0, 3'b000, 1'b0);

        // Overload holds the door at floor 2
        pulse(3'b010);
        step_expect("t4_go",   2'b01, 2'b01, 1'b0, 3'b010, 1'b1);
        step_expect("t4_m1",   2'b01, 2'b01, 1'b0, 3'b010, 1'b1);
        step_expect("t4_arr2", 2'b10, 2'b01, 1'b1, 3'b000, 1'b1);
        bus.alarm = 1'b1;
        pulse(3'b100);
        for (int i = 0; i < 10; i++) begin
            step_expect("t4_hold", 2'b10, 2'b01, 1'b1, 3'b100, 1'b1);
        end
        bus.alarm = 1'b0;
        step_expect("t4_c1",  2'b10, 2'b01, 1'b1, 3'b100, 1'b1);
        step_expect("t4_c2",  2'b10, 2'b01, 1'b1, 3'b100, 1'b1);
        step_expect("t4_dep", 2'b10, 2'b01, 1'b0, 3'b100, 1'b1);
        run_steps(5);
        push_all("t4_end", 2'b11, 2'b00, 1'b0, 3'b000, 1'b0);
        check();

        // Tie at floor 2 goes up
        pulse(3'b010);
        run_steps(6);
        push_all("t5_home", 2'b10, 2'b00, 1'b0, 3'b000, 1'b0);
        check();
        pulse(3'b101);
        push("t5_pend", F_PEND, 4'b0101);
        check();
        step_expect("t5_tie",  2'b10, 2'b01, 1'b0, 3'b101, 1'b1);
        step_expect("t5_m1",   2'b10, 2'b01, 1'b0, 3'b101, 1'b1);
        step_expect("t5_arr3", 2'b11, 2'b01, 1'b1, 3'b001, 1'b1);
        run_steps(2);
        step_expect("t5_rev",  2'b11, 2'b10, 1'b0, 3'b001, 1'b1);
        run_steps(3);
        step_expect("t5_arr1", 2'b01, 2'b10, 1'b1, 3'b000, 1'b1);
        run_steps(3);

        // Capture latency and a same-floor call while the door is open
        bus.CH1 = 1'b1;
        repeat (2) tick();
        push("t7_lat2", F_PEND, 4'b0000);
        check();
        tick();
        push("t7_lat3", F_PEND, 4'b0001);
        check();
        bus.CH1 = 1'b0;
        step_expect("t7_open", 2'b01, 2'b00, 1'b1, 3'b000, 1'b1);
        run_steps(1);
        pulse(3'b001);
        push("t7_noset", F_PEND, 4'b0000);
        check();
        step_expect("t7_r1",    2'b01, 2'b00, 1'b1, 3'b000, 1'b1);
        step_expect("t7_r2",    2'b01, 2'b00, 1'b1, 3'b000, 1'b1);
        step_expect("t7_close", 2'b01, 2'b00, 1'b0, 3'b000, 1'b0);

        // Asynchronous reset mid-travel
        pulse(3'b100);
        step_expect("t6_go", 2'b01, 2'b01, 1'b0, 3'b100, 1'b1);
        run_steps(2);
        push_all("t6_mid", 2'b10, 2'b01, 1'b0, 3'b100, 1'b1);
        check();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        push_all("t6_rst", 2'b01, 2'b00, 1'b0, 3'b000, 1'b0);
        check();
        #2 reset = 1'b1;
        tick();
        push_all("t6_after", 2'b01, 2'b00, 1'b0, 3'b000, 1'b0);
        check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
